// File: rtl/m_mem_ctrl.sv
// MEM-stage data-bus controller: issues one load/store per instruction,
// freezes the pipeline while waiting for bus_ack, extends load data and
// aborts with a bus_err pulse after TIMEOUT unacknowledged BUSY cycles.
module m_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_valid,
    input  logic [1:0]  M_sel_st,
    input  logic [2:0]  M_sel_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteEn,
    input  logic        AdES,
    input  logic        AdEL,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             is_st;
    logic             is_ld;
    logic             start;
    logic             expire;

    logic             st_q;
    logic [2:0]       sel_ld_q;
    logic [1:0]       lane_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ld_data_q;
    logic             ld_valid_q;
    logic             bus_err_q;

    // Extend the selected lane of a read word according to the load kind.
    function automatic logic [31:0] extend(input logic [2:0]  sel,
                                           input logic [1:0]  lane,
                                           input logic [31:0] d);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = lane[1] ? d[31:16] : d[15:0];
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        case (sel)
            3'd1:    r = d;
            3'd2:    r = {{16{h[15]}}, h};
            3'd3:    r = {16'h0000, h};
            3'd4:    r = {{24{b[7]}}, b};
            3'd5:    r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Decode the start condition; a store takes priority over a load.
    always_comb begin
        is_st  = (M_sel_st != 2'b11);
        is_ld  = (M_sel_ld >= 3'd1) && (M_sel_ld <= 3'd5);
        start  = M_valid && !AdES && !AdEL && (is_st || is_ld);
        expire = (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; an ack on the expiring cycle counts as success.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (bus_ack || expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; stall is forced low while reset is held.
    always_comb begin
        bus_req = 1'b0;
        bus_we  = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: stall = start && !reset;
            BUSY: begin
                bus_req = 1'b1;
                bus_we  = st_q;
                stall   = 1'b1;
            end
            default: ;
        endcase
    end

    // Latch the request at start, count BUSY cycles, capture the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q       <= 1'b0;
            sel_ld_q   <= 3'd0;
            lane_q     <= 2'd0;
            addr_q     <= 32'h0000_0000;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0000_0000;
            cnt        <= '0;
            ld_data_q  <= 32'h0000_0000;
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        st_q     <= is_st;
                        sel_ld_q <= is_st ? 3'd0 : M_sel_ld;
                        lane_q   <= addr[1:0];
                        addr_q   <= {addr[31:2], 2'b00};
                        be_q     <= is_st ? byteEn : 4'h0;
                        case (M_sel_st)
                            2'b01:   wdata_q <= {2{wdata[15:0]}};
                            2'b10:   wdata_q <= {4{wdata[7:0]}};
                            default: wdata_q <= wdata;
                        endcase
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (!st_q) begin
                            ld_data_q  <= extend(sel_ld_q, lane_q, bus_rdata);
                            ld_valid_q <= 1'b1;
                        end
                    end else if (expire) begin
                        ld_data_q <= 32'h0000_0000;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign ld_data   = ld_data_q;
    assign ld_valid  = ld_valid_q;
    assign bus_err   = bus_err_q;

endmodule
